// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between fetch (master) and memory (slave).
interface fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched word, holds under stall, flushes to a bubble.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc4,
  output logic [31:0] instruccion,
  output logic [31:0] PCmas4,
  output logic        inst_valid
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  // Load wins over flush; the caller already masks load on a redirect.
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (load) begin
      instr_d = load_instr;
      pc4_d   = load_pc4;
      valid_d = 1'b1;
    end else if (flush) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= RESET_PC + 32'd4;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instruccion = instr_q;
  assign PCmas4      = pc4_q;
  assign inst_valid  = valid_q;

endmodule

// File: rtl/fetch.sv
// Instruction fetch: single-outstanding memory requests, branch redirect with
// stale-response discard, feeding the IF/ID register.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Select_PC,
  input  logic [31:0] dir_salto,
  input  logic        stall,
  fetch_if.master     imem,
  output logic [31:0] instruccion,
  output logic [31:0] PCmas4,
  output logic        inst_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_plus4;
  logic         redirect, slot_free, load, flush;

  assign pc_plus4  = pc_q + 32'd4;
  assign redirect  = Select_PC & inst_valid;
  assign slot_free = ~inst_valid | ~stall;
  assign load      = (state_q == S_WAIT) & imem.imem_rvalid & ~redirect;
  // A consumed slot with nothing arriving becomes a bubble.
  assign flush     = redirect | (inst_valid & ~stall & ~load);

  assign imem.imem_req  = ~reset & (state_q == S_REQ) & slot_free & ~redirect;
  assign imem.imem_addr = word_align(pc_q);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_REQ: begin
        if (redirect) pc_d = word_align(dir_salto);
        else if (imem.imem_req && imem.imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d    = word_align(dir_salto);
          state_d = imem.imem_rvalid ? S_REQ : S_DISCARD;
        end else if (imem.imem_rvalid) begin
          pc_d    = pc_plus4;
          state_d = S_REQ;
        end
      end
      S_DISCARD: begin
        if (redirect) pc_d = word_align(dir_salto);
        if (imem.imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  if_id_reg #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .flush       (flush),
    .load_instr  (imem.imem_rdata),
    .load_pc4    (pc_plus4),
    .instruccion (instruccion),
    .PCmas4      (PCmas4),
    .inst_valid  (inst_valid)
  );

endmodule

// File: tb/tb_fetch.sv
// Randomized bench for fetch: memory responder plus a transaction-level reference model
// whose per-cycle expectations are queued and checked by an independent monitor.
module tb_fetch;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        Select_PC;
  logic [31:0] dir_salto;
  logic        stall;
  logic [31:0] instruccion;
  logic [31:0] PCmas4;
  logic        inst_valid;

  fetch_if bus ();

  fetch #(
    .RESET_PC  (RST_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Select_PC   (Select_PC),
    .dir_salto   (dir_salto),
    .stall       (stall),
    .imem        (bus),
    .instruccion (instruccion),
    .PCmas4      (PCmas4),
    .inst_valid  (inst_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0003;
  endfunction

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ins;
    logic [31:0] p4;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT shows mid-cycle against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("imem_req", {31'd0, bus.imem_req}, {31'd0, e.req});
      if (e.req) chk("imem_addr", bus.imem_addr, e.addr);
      chk("inst_valid", {31'd0, inst_valid}, {31'd0, e.vld});
      chk("instruccion", instruccion, e.ins);
      chk("PCmas4", PCmas4, e.p4);
    end
  end

  // Reference model state: architectural view only.
  logic [31:0] m_pc, m_ins, m_p4;
  logic        m_vld, m_out, m_stale;
  int          accepted = 0;

  initial begin
    logic        mb, fire, rv_real, want_rst;
    logic [31:0] maddr, faddr;
    int          mcnt, lat, rst_cnt, mode;
    logic        redir, free, req, resp, acc, nout, nst;
    exp_t        e;

    reset = 1'b1; stall = 1'b0; Select_PC = 1'b0; dir_salto = '0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    mb = 1'b0; fire = 1'b0; rv_real = 1'b0; want_rst = 1'b0;
    maddr = '0; faddr = '0; mcnt = 0; rst_cnt = 0;
    m_pc = RST_PC; m_ins = NOP; m_p4 = RST_PC + 32'd4;
    m_vld = 1'b0; m_out = 1'b0; m_stale = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      // 0: reset, 1: clean streaming, 2: random traffic
      mode = (cyc < 3) ? 0 : (cyc < 40) ? 1 : 2;
      if (cyc == 1400) want_rst = 1'b1;

      // Memory responder bookkeeping for the previous cycle
      if (rv_real) mb = 1'b0;
      if (fire) begin
        lat = (mode == 1) ? 1 : want_rst ? 6 : $urandom_range(1, 3);
        mb = 1'b1; mcnt = lat; maddr = faddr;
        if (want_rst) begin rst_cnt = 2; want_rst = 1'b0; end
      end

      reset = (mode == 0) || (rst_cnt > 0);
      if (rst_cnt > 0) rst_cnt--;

      if (mode == 2 && !want_rst) begin
        stall     = ($urandom % 4) == 0;
        Select_PC = ($urandom % 6) == 0;
        case ($urandom % 3)
          0:       dir_salto = $urandom;
          1:       dir_salto = 32'hFFFF_FFF0 | ($urandom % 16);
          default: dir_salto = 32'h0000_0100 | ($urandom % 4);
        endcase
        bus.imem_gnt = !mb && (($urandom % 3) != 0);
      end else begin
        stall = 1'b0; Select_PC = 1'b0; dir_salto = 32'h0000_0100;
        bus.imem_gnt = !mb;
      end

      rv_real = 1'b0;
      if (mb) begin
        mcnt--;
        if (mcnt == 0) rv_real = 1'b1;
      end
      bus.imem_rvalid = rv_real;
      bus.imem_rdata  = rv_real ? mem_word(maddr) : (32'hDEAD_0000 | ($urandom % 65536));
      if (!mb && mode == 2 && ($urandom % 8) == 0) bus.imem_rvalid = 1'b1;

      // Reference model: expectation for this cycle, then advance
      if (reset) begin
        m_pc = RST_PC; m_out = 1'b0; m_stale = 1'b0;
        m_vld = 1'b0; m_ins = NOP; m_p4 = RST_PC + 32'd4;
        e.req = 1'b0; e.addr = RST_PC; e.vld = 1'b0; e.ins = NOP; e.p4 = RST_PC + 32'd4;
        sb.push_back(e);
      end else begin
        redir = Select_PC && m_vld;
        free  = !m_vld || !stall;
        req   = !m_out && free && !redir;
        e.req = req; e.addr = m_pc; e.vld = m_vld; e.ins = m_ins; e.p4 = m_p4;
        sb.push_back(e);

        resp = m_out && bus.imem_rvalid;
        acc  = resp && !m_stale && !redir;
        nout = m_out; nst = m_stale;
        if (resp) begin nout = 1'b0; nst = 1'b0; end
        else if (m_out && redir) nst = 1'b1;
        if (req && bus.imem_gnt) nout = 1'b1;

        if (acc) begin
          m_ins = mem_word(m_pc); m_p4 = m_pc + 32'd4; m_vld = 1'b1; m_pc = m_pc + 32'd4;
          accepted++;
        end else if (redir) begin
          m_pc = dir_salto & ~32'd3; m_vld = 1'b0; m_ins = NOP;
        end else if (m_vld && !stall) begin
          m_vld = 1'b0; m_ins = NOP;
        end
        m_out = nout; m_stale = nst;
      end

      @(negedge clk);
      fire  = bus.imem_req && bus.imem_gnt;
      faddr = bus.imem_addr;
    end

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    chk("instructions_delivered", {31'd0, (accepted > 100)}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), SHALL be the instruction driven while the output slot is empty.
REQ-003 clk  input  1  processor clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  reset; asynchronous, active-high.
REQ-005 Select_PC  input  1  taken-branch redirect request from Decode.
REQ-006 dir_salto  input  32  redirect target from Decode.
REQ-007 stall  input  1  Decode cannot accept a new instruction this cycle.
REQ-008 imem_req  output  1  instruction-memory request valid.
REQ-009 imem_addr  output  32  request address, word aligned.
REQ-010 imem_gnt  input  1  memory accepts the request this cycle.
REQ-011 imem_rvalid  input  1  response data valid; at least 1 cycle after grant.
REQ-012 imem_rdata  input  32  response instruction word.
REQ-013 instruccion  output  32  IF/ID registered instruction to Decode.
REQ-014 PCmas4  output  32  IF/ID registered fetch PC + 4 to Decode.
REQ-015 inst_valid  output  1  instruccion/PCmas4 hold a live instruction.

Function
REQ-016 States SHALL be S_REQ (request may issue), S_WAIT (one request outstanding) and S_DISCARD (outstanding response is stale).
REQ-017 At most one memory request SHALL be outstanding at any time.
REQ-018 Slot free SHALL mean inst_valid=0 or (inst_valid=1 and stall=0).
REQ-019 In S_REQ, imem_req SHALL be 1 only while the slot is free; imem_addr SHALL equal {pc[31:2],2'b00}; imem_req&imem_gnt SHALL move the block to S_WAIT.
REQ-020 In S_WAIT, imem_rvalid SHALL load instruccion<=imem_rdata, PCmas4<=pc+4, inst_valid<=1 and pc<=pc+4, and SHALL move the block to S_REQ; fetch-to-output latency SHALL be grant-to-rvalid plus 1 cycle.
REQ-021 When the slot is consumed (inst_valid=1, stall=0) and no response loads, inst_valid SHALL clear to 0 and instruccion SHALL become NOP_INSTR.
REQ-022 While inst_valid=1 and stall=1, instruccion, PCmas4 and inst_valid SHALL hold.
REQ-023 Select_PC SHALL be honoured only when inst_valid=1 and SHALL take priority over stall and over a same-cycle response.
REQ-024 On redirect: pc<=dir_salto&~3, inst_valid<=0, instruccion<=NOP_INSTR, and imem_req SHALL be 0 that cycle.
REQ-025 If a redirect occurs in S_WAIT without imem_rvalid, the block SHALL go to S_DISCARD; if imem_rvalid coincides, the response SHALL be dropped and the block SHALL go to S_REQ.
REQ-026 In S_DISCARD, imem_req SHALL be 0; imem_rvalid SHALL be dropped and SHALL move the block to S_REQ; a further redirect SHALL only update pc.
REQ-027 imem_rvalid in S_REQ SHALL be ignored.
REQ-028 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).

Reset
REQ-029 Reset SHALL asynchronously force pc=RESET_PC, state=S_REQ, inst_valid=0, instruccion=NOP_INSTR, PCmas4=RESET_PC+4, imem_req=0.
REQ-030 Reset mid-request SHALL abandon the outstanding request; the first request after deassertion SHALL be to RESET_PC.

Structure
REQ-031 Package fetch_pkg SHALL hold the state enum, the RESET_PC default and the NOP_INSTR constant.
REQ-032 The IF/ID output register with hold and flush SHALL be one sub-module, if_id_reg.

Verification
REQ-033 Reset, gnt=1, rvalid 1 cycle after grant, stall=0 -> addresses 0,4,8 issued; outputs (0x13,PCmas4=4),(…,8) with inst_valid pulses.
REQ-034 stall=1 for 3 cycles with inst_valid=1 -> outputs frozen, imem_req=0, no pc change; stall release -> next fetch issues the same cycle.
REQ-035 Select_PC=1, dir_salto=0x100 in S_WAIT, rvalid 2 cycles later -> that response dropped, next imem_addr=0x100, inst_valid=0 until the 0x100 response.
REQ-036 Select_PC=1 coincident with imem_rvalid -> response dropped, next imem_addr=dir_salto, S_REQ directly.
REQ-037 RESET_PC=32'hFFFF_FFFC -> first PCmas4=0, second imem_addr=0.
REQ-038 Reset asserted in S_WAIT, then late rvalid after deassertion -> rvalid ignored, imem_addr=RESET_PC, inst_valid=0.
